// File: rtl/booth_radix4_mul.sv
// rtl/booth_radix4_mul.sv - sequential radix-4 Booth multiplier with start/done handshake
module booth_radix4_mul #(
    parameter int DATA_SIZE = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     start_i,
    input  logic                     clear_i,
    input  logic                     signed_mode_i,
    input  logic [DATA_SIZE-1:0]     multiplicand_i,
    input  logic [DATA_SIZE-1:0]     multiplier_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [2*DATA_SIZE-1:0]   product_o
);

    localparam int W  = DATA_SIZE + 2;
    localparam int N  = W / 2;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W:0]        acc_q;
    logic [W-1:0]      mcand_q;
    logic [W-1:0]      mplier_q;
    logic              q_m1_q;
    logic [CW-1:0]     cnt_q;

    logic              accept;
    logic              step_en;
    logic              last_step;
    logic [W-1:0]      mcand_ext;
    logic [W-1:0]      mplier_ext;
    logic [W:0]        m_x1;
    logic [W:0]        m_x2;
    logic [W:0]        addend;
    logic [W:0]        sum;
    logic [W:0]        acc_next;
    logic [W-1:0]      mplier_next;
    logic [2*DATA_SIZE-1:0] product_next;

    assign accept    = (state_q != S_CALC) && start_i && !clear_i;
    assign step_en   = (state_q == S_CALC) && !clear_i;
    assign last_step = (cnt_q == CW'(1));

    // Two guard bits make the extended operand wide enough to hold -2M for the most-negative M
    assign mcand_ext  = signed_mode_i ? {{2{multiplicand_i[DATA_SIZE-1]}}, multiplicand_i}
                                      : {2'b00, multiplicand_i};
    assign mplier_ext = signed_mode_i ? {{2{multiplier_i[DATA_SIZE-1]}}, multiplier_i}
                                      : {2'b00, multiplier_i};

    assign m_x1 = {mcand_q[W-1], mcand_q};
    assign m_x2 = {mcand_q, 1'b0};

    always_comb begin
        addend = '0;
        case ({mplier_q[1:0], q_m1_q})
            3'b001, 3'b010: addend = m_x1;
            3'b011:         addend = m_x2;
            3'b100:         addend = -m_x2;
            3'b101, 3'b110: addend = -m_x1;
            default:        addend = '0;
        endcase
    end

    // Add the recoded digit, then arithmetic-shift {acc,Q,q_m1} right by two
    assign sum          = acc_q + addend;
    assign acc_next     = {{2{sum[W]}}, sum[W:2]};
    assign mplier_next  = {sum[1:0], mplier_q[W-1:2]};
    assign product_next = {acc_next[DATA_SIZE-3:0], mplier_next};

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_i) state_d = S_CALC;
                S_CALC:  if (last_step) state_d = S_DONE;
                S_DONE:  state_d = start_i ? S_CALC : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = (state_q == S_CALC);
        done_o = (state_q == S_DONE);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            q_m1_q    <= 1'b0;
            cnt_q     <= '0;
            product_o <= '0;
        end else if (accept) begin
            acc_q    <= '0;
            mcand_q  <= mcand_ext;
            mplier_q <= mplier_ext;
            q_m1_q   <= 1'b0;
            cnt_q    <= CW'(N);
        end else if (step_en) begin
            acc_q    <= acc_next;
            mplier_q <= mplier_next;
            q_m1_q   <= mplier_q[1];
            cnt_q    <= cnt_q - CW'(1);
            if (last_step) begin
                product_o <= product_next;
            end
        end
    end

endmodule

// File: tb/tb_booth_radix4_mul.sv
// tb/tb_booth_radix4_mul.sv - directed and random checks of booth_radix4_mul at 8 and 16 bits
module tb_booth_radix4_mul;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        start_i, clear_i, signed_mode_i;
    logic [7:0]  mc, mq;
    logic        busy, done;
    logic [15:0] product;

    logic        start16, clear16, signed16;
    logic [15:0] mc16, mq16;
    logic        busy16, done16;
    logic [31:0] product16;

    int pass_cnt = 0;
    int total    = 0;

    booth_radix4_mul #(.DATA_SIZE(8)) dut8 (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .start_i        (start_i),
        .clear_i        (clear_i),
        .signed_mode_i  (signed_mode_i),
        .multiplicand_i (mc),
        .multiplier_i   (mq),
        .busy_o         (busy),
        .done_o         (done),
        .product_o      (product)
    );

    booth_radix4_mul #(.DATA_SIZE(16)) dut16 (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .start_i        (start16),
        .clear_i        (clear16),
        .signed_mode_i  (signed16),
        .multiplicand_i (mc16),
        .multiplier_i   (mq16),
        .busy_o         (busy16),
        .done_o         (done16),
        .product_o      (product16)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget && n == 0; i++) begin
            tick();
            if (done) n = i;
        end
    endtask

    task automatic run_op8(input logic [7:0] m, input logic [7:0] q, input logic s,
                           output logic [15:0] prod, output int lat, output int pulses,
                           output logic bsy);
        start_i = 1'b1; mc = m; mq = q; signed_mode_i = s;
        tick();
        bsy = busy;
        start_i = 1'b0; mc = 8'($urandom); mq = 8'($urandom); signed_mode_i = 1'($urandom);
        lat = 0; pulses = 0; prod = '0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick();
            if (done) begin lat = i; prod = product; pulses = 1; end
        end
        repeat (2) begin
            tick();
            if (done) pulses++;
        end
    endtask

    task automatic run_op16(input logic [15:0] m, input logic [15:0] q, input logic s,
                            output logic [31:0] prod, output int lat, output int pulses);
        start16 = 1'b1; mc16 = m; mq16 = q; signed16 = s;
        tick();
        start16 = 1'b0; mc16 = 16'($urandom); mq16 = 16'($urandom);
        lat = 0; pulses = 0; prod = '0;
        for (int i = 1; i <= 30 && lat == 0; i++) begin
            tick();
            if (done16) begin lat = i; prod = product16; pulses = 1; end
        end
        repeat (2) begin
            tick();
            if (done16) pulses++;
        end
    endtask

    logic [15:0] p8;
    logic [31:0] p16;
    logic        b;
    int          lat, pulses, n, n2, cnt, errs;
    logic [7:0]  rm, rq;
    logic [15:0] rm16, rq16;
    logic        rs;
    longint      e;

    initial begin
        reset_ni = 1'b0; start_i = 1'b0; clear_i = 1'b0; signed_mode_i = 1'b0; mc = '0; mq = '0;
        start16 = 1'b0; clear16 = 1'b0; signed16 = 1'b0; mc16 = '0; mq16 = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_product", 32'(product), 32'h0);
        reset_ni = 1'b1;
        tick();

        run_op8(8'h80, 8'h80, 1'b1, p8, lat, pulses, b);
        check("s_min_busy", 32'(b), 32'h1);
        check("s_min_prod", 32'(p8), 32'h4000);
        check("s_min_latency", 32'(lat), 32'd5);
        check("s_min_pulses", 32'(pulses), 32'd1);
        check("s_min_hold", 32'(product), 32'h4000);

        run_op8(8'hFF, 8'hFF, 1'b0, p8, lat, pulses, b);
        check("u_ff_prod", 32'(p8), 32'hFE01);
        check("u_ff_latency", 32'(lat), 32'd5);
        run_op8(8'hFF, 8'hFF, 1'b1, p8, lat, pulses, b);
        check("s_ff_prod", 32'(p8), 32'h0001);
        check("s_ff_pulses", 32'(pulses), 32'd1);
        run_op8(8'hFD, 8'h05, 1'b1, p8, lat, pulses, b);
        check("s_m3x5_prod", 32'(p8), 32'hFFF1);
        check("s_m3x5_latency", 32'(lat), 32'd5);

        // start pulsed mid-operation must be ignored
        start_i = 1'b1; mc = 8'h07; mq = 8'h09; signed_mode_i = 1'b0;
        tick();
        start_i = 1'b0;
        tick();
        start_i = 1'b1; mc = 8'h55; mq = 8'h66; signed_mode_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(20, n);
        check("busy_start_latency", 32'(n + 2), 32'd5);
        check("busy_start_prod", 32'(product), 32'h003F);
        cnt = 0;
        repeat (8) begin tick(); if (done) cnt++; end
        check("busy_start_no_extra_done", 32'(cnt), 32'd0);

        // clear in the third CALC cycle
        start_i = 1'b1; mc = 8'h12; mq = 8'h34; signed_mode_i = 1'b0;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clear_busy", 32'(busy), 32'h0);
        check("clear_done", 32'(done), 32'h0);
        check("clear_product", 32'(product), 32'h003F);
        cnt = 0;
        repeat (8) begin tick(); if (done) cnt++; end
        check("clear_no_done", 32'(cnt), 32'd0);
        check("clear_product_held", 32'(product), 32'h003F);

        // asynchronous reset mid-CALC
        start_i = 1'b1; mc = 8'h12; mq = 8'h34; signed_mode_i = 1'b0;
        tick();
        start_i = 1'b0;
        tick();
        check("pre_reset_busy", 32'(busy), 32'h1);
        reset_ni = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        check("async_rst_product", 32'(product), 32'h0);
        tick();
        reset_ni = 1'b1;
        tick();

        // back-to-back: start held during DONE
        start_i = 1'b1; mc = 8'h0A; mq = 8'h0B; signed_mode_i = 1'b0;
        tick();
        start_i = 1'b0;
        wait_done(20, n);
        check("b2b_first_latency", 32'(n), 32'd5);
        check("b2b_first_prod", 32'(product), 32'h006E);
        start_i = 1'b1; mc = 8'hF6; mq = 8'h07; signed_mode_i = 1'b1;
        tick();
        start_i = 1'b0; mc = 8'h00; mq = 8'h00;
        wait_done(20, n2);
        check("b2b_gap", 32'(n2 + 1), 32'd6);
        check("b2b_second_prod", 32'(product), 32'hFFBA);
        repeat (2) tick();

        errs = 0;
        for (int i = 0; i < 2000; i++) begin
            rm = 8'($urandom); rq = 8'($urandom); rs = 1'($urandom);
            if (rs) e = longint'($signed(rm)) * longint'($signed(rq));
            else    e = longint'(rm) * longint'(rq);
            run_op8(rm, rq, rs, p8, lat, pulses, b);
            if (p8 !== e[15:0] || lat != 5 || pulses != 1) errs++;
        end
        check("rand8_errors", 32'(errs), 32'd0);

        run_op16(16'h8000, 16'h8000, 1'b1, p16, lat, pulses);
        check("d16_min_prod", p16, 32'h4000_0000);
        check("d16_min_latency", 32'(lat), 32'd9);
        run_op16(16'hFFFF, 16'hFFFF, 1'b0, p16, lat, pulses);
        check("d16_uff_prod", p16, 32'hFFFE_0001);

        errs = 0;
        for (int i = 0; i < 2000; i++) begin
            rm16 = 16'($urandom); rq16 = 16'($urandom); rs = 1'($urandom);
            if (rs) e = longint'($signed(rm16)) * longint'($signed(rq16));
            else    e = longint'(rm16) * longint'(rq16);
            run_op16(rm16, rq16, rs, p16, lat, pulses);
            if (p16 !== e[31:0] || lat != 9 || pulses != 1) errs++;
        end
        check("rand16_errors", 32'(errs), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
